// File: rtl/alu_ctrl_mdu.sv
// alu_ctrl_mdu
//   ALU control decoder for the DPTR datapath plus an iterative
//   multiply/divide unit that owns the HI/LO registers.
//
//   Ports
//     clk, rst_n      : clock, synchronous active-low reset
//     ALUOp, funct    : main-control opcode class and R-type function field
//     valid           : instruction on ALUOp/funct/a/b is live this cycle
//     a, b            : rs / rt operands
//     sel             : ALU select (combinational, 4-bit codes zero-extended)
//     hilo_rd         : 01 = mfhi, 10 = mflo, 00 = neither (combinational)
//     hi, lo          : HI/LO registers
//     busy            : MDU is running (registered)
//     stall           : freeze the issuing stage (combinational)
module alu_ctrl_mdu #(
  parameter int W     = 32,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       funct,
  input  logic             valid,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic [SEL_W-1:0] sel,
  output logic [1:0]       hilo_rd,
  output logic [W-1:0]     hi,
  output logic [W-1:0]     lo,
  output logic             busy,
  output logic             stall
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam int CW = $clog2(W);

  // ---------------------------------------------------------------- decode
  logic [3:0] sel4;

  always_comb begin
    sel4 = 4'b0000;
    case (ALUOp)
      2'b00: sel4 = 4'b0010;
      2'b01: sel4 = 4'b0110;
      2'b10: begin
        case (funct)
          6'b100000: sel4 = 4'b0010;
          6'b100010: sel4 = 4'b0110;
          6'b100100: sel4 = 4'b0000;
          6'b100101: sel4 = 4'b0001;
          6'b101010: sel4 = 4'b0111;
          6'b100110: sel4 = 4'b0011;
          6'b100111: sel4 = 4'b1100;
          6'b101011: sel4 = 4'b1000;
          default:   sel4 = 4'b0000;
        endcase
      end
      default: sel4 = 4'b0000;
    endcase
  end

  assign sel = SEL_W'(sel4);

  logic rtype;
  logic is_mul, is_div, is_signed;
  logic is_mfhi, is_mthi, is_mflo, is_mtlo;
  logic mdu_grp, accept, start;

  assign rtype     = valid && (ALUOp == 2'b10);
  assign is_mul    = (funct == 6'b011000) || (funct == 6'b011001);
  assign is_div    = (funct == 6'b011010) || (funct == 6'b011011);
  // Even funct codes of the mult/div pairs are the signed variants.
  assign is_signed = ~funct[0];
  assign is_mfhi   = (funct == 6'b010000);
  assign is_mthi   = (funct == 6'b010001);
  assign is_mflo   = (funct == 6'b010010);
  assign is_mtlo   = (funct == 6'b010011);
  assign mdu_grp   = is_mul || is_div || is_mfhi || is_mthi || is_mflo || is_mtlo;

  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign busy    = (state_q != S_IDLE);
  assign stall   = rtype && mdu_grp && busy;
  assign accept  = rtype && mdu_grp && !busy;
  assign start   = accept && (is_mul || is_div);
  assign hilo_rd = {rtype && is_mflo && !stall, rtype && is_mfhi && !stall};

  // --------------------------------------------------------------- datapath
  // prod_q holds {upper, lower}: for multiply the partial product with the
  // multiplier shifting out of the bottom; for divide {remainder, quotient}
  // with the dividend shifting out of the top of the lower half.
  logic [2*W-1:0] prod_q;
  logic [W-1:0]   mcand_q;    // multiplicand or divisor magnitude
  logic           is_div_q;
  logic           neg_q;      // negate product / quotient in FIX
  logic           neg_rem_q;  // remainder follows dividend sign
  logic           dz_q;       // divide by zero
  logic [W-1:0]   dvd_q;      // original dividend, returned in HI on div-by-zero

  logic [W-1:0] a_mag, b_mag;
  assign a_mag = (is_signed && a[W-1]) ? -a : a;
  assign b_mag = (is_signed && b[W-1]) ? -b : b;

  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     div_shift, div_diff;
  logic [2*W-1:0] div_next;

  assign mul_sum  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
  assign mul_next = {mul_sum, prod_q[W-1:1]};

  assign div_shift = {prod_q[2*W-1:W], prod_q[W-1]};
  assign div_diff  = div_shift - {1'b0, mcand_q};
  // A borrow means the trial subtraction failed: keep the shifted remainder.
  assign div_next  = div_diff[W] ? {div_shift[W-1:0], prod_q[W-2:0], 1'b0}
                                 : {div_diff[W-1:0],  prod_q[W-2:0], 1'b1};

  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_q     ? -prod_q           : prod_q;
  assign quo_fix  = neg_q     ? -prod_q[W-1:0]    : prod_q[W-1:0];
  assign rem_fix  = neg_rem_q ? -prod_q[2*W-1:W]  : prod_q[2*W-1:W];

  // ----------------------------------------------------------- next state
  logic [W-1:0] hi_q, hi_d, lo_q, lo_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d = S_FIX;
          cnt_d   = '0;
        end
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    // accept implies idle, so moves never collide with a FIX write-back
    if (accept && is_mthi) hi_d = a;
    if (accept && is_mtlo) lo_d = a;
    if (state_q == S_FIX) begin
      if (!is_div_q) begin
        hi_d = prod_fix[2*W-1:W];
        lo_d = prod_fix[W-1:0];
      end else if (dz_q) begin
        hi_d = dvd_q;
        lo_d = '1;
      end else begin
        hi_d = rem_fix;
        lo_d = quo_fix;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Operand/iteration registers need no reset: they are only consumed
  // after a start has loaded them.
  always_ff @(posedge clk) begin
    if (start) begin
      is_div_q  <= is_div;
      neg_q     <= is_signed && (a[W-1] ^ b[W-1]);
      neg_rem_q <= is_signed && a[W-1];
      dz_q      <= is_div && (b == '0);
      dvd_q     <= a;
      prod_q    <= is_div ? {{W{1'b0}}, a_mag} : {{W{1'b0}}, b_mag};
      mcand_q   <= is_div ? b_mag : a_mag;
    end else if (state_q == S_RUN) begin
      prod_q <= is_div_q ? div_next : mul_next;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Testbench for alu_ctrl_mdu: decoder sweep, MDU ops through a scoreboard,
// stall/hilo_rd behaviour and reset in the middle of an operation.
module tb_alu_ctrl_mdu;
  localparam int W = 32;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   ALUOp;
  logic [5:0]   funct;
  logic         valid;
  logic [W-1:0] a, b;
  logic [3:0]   sel;
  logic [1:0]   hilo_rd;
  logic [W-1:0] hi, lo;
  logic         busy, stall;

  alu_ctrl_mdu #(.W(W), .SEL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .funct(funct), .valid(valid),
    .a(a), .b(b), .sel(sel), .hilo_rd(hilo_rd), .hi(hi), .lo(lo),
    .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference {HI,LO} for a multi-cycle op.
  function automatic logic [63:0] mdu_model(input logic [5:0] f, input logic [31:0] x,
                                            input logic [31:0] y);
    logic [63:0] r;
    int sx, sy;
    longint px;
    sx = x;
    sy = y;
    r  = '0;
    case (f)
      F_MULT: begin
        px = longint'(sx) * longint'(sy);
        r  = px;
      end
      F_MULTU: r = {32'b0, x} * {32'b0, y};
      F_DIVU: begin
        if (y == 0) r = {x, 32'hFFFF_FFFF};
        else        r = {x % y, x / y};
      end
      F_DIV: begin
        if (y == 0)                                        r = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else                                               r = {32'(sx % sy), 32'(sx / sy)};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Count remaining busy cycles, then compare HI/LO against the scoreboard.
  task automatic wait_done(input string name, input int already);
    int bcnt;
    logic [63:0] e;
    bcnt = already;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      else break;
    end
    check({name, " busy cycles"}, 64'(bcnt), 64'(W + 1));
    if (exp_q.size() == 0) begin
      check({name, " scoreboard entry"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check({name, " hi"}, 64'(hi), 64'(e[63:32]));
      check({name, " lo"}, 64'(lo), 64'(e[31:0]));
      $display("%s: hi=%h lo=%h (expected %h %h)", name, hi, lo, e[63:32], e[31:0]);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] x,
                        input logic [31:0] y);
    wait_idle();
    ALUOp = 2'b10; funct = f; a = x; b = y; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    exp_q.push_back(mdu_model(f, x, y));
    wait_done(name, 0);
  endtask

  logic [5:0] ftab [10] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                            6'b100110, 6'b100111, 6'b101011, 6'b000000, 6'b011000};
  logic [3:0] stab [10] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111,
                            4'b0011, 4'b1100, 4'b1000, 4'b0000, 4'b0000};
  logic [5:0] optab [4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};

  initial begin
    int scnt, bad_rd;
    logic [63:0] e;
    logic [3:0] es;
    logic [31:0] rx, ry;
    logic [5:0] rf;

    rst_n = 1'b0; valid = 1'b0; ALUOp = 2'b00; funct = 6'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset stall", 64'(stall), 64'd0);

    // Decoder sweep
    for (int op = 0; op < 4; op++) begin
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        ALUOp = 2'(op); funct = ftab[k];
        #1;
        case (op)
          0:       es = 4'b0010;
          1:       es = 4'b0110;
          2:       es = stab[k];
          default: es = 4'b0000;
        endcase
        check($sformatf("sel op=%0d funct=%b", op, ftab[k]), 64'(sel), 64'(es));
      end
    end
    $display("decoder sweep done");

    // mfhi / mflo when idle
    @(negedge clk);
    ALUOp = 2'b10; funct = F_MFHI; valid = 1'b1; #1;
    check("hilo_rd mfhi", 64'(hilo_rd), 64'd1);
    funct = F_MFLO; #1;
    check("hilo_rd mflo", 64'(hilo_rd), 64'd2);
    valid = 1'b0; #1;
    check("hilo_rd invalid", 64'(hilo_rd), 64'd0);

    run_op("mult -3*7",        F_MULT,  32'hFFFF_FFFD, 32'd7);
    run_op("multu max*max",    F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("divu 100/7",       F_DIVU,  32'd100,       32'd7);
    run_op("div -7/2",         F_DIV,   32'hFFFF_FFF9, 32'd2);
    run_op("div 5/0",          F_DIV,   32'd5,         32'd0);
    run_op("divu 9/0",         F_DIVU,  32'd9,         32'd0);
    run_op("div ovf",          F_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div 7/-2",         F_DIV,   32'd7,         32'hFFFF_FFFE);

    // Stall: mflo held from E0+1 until the result lands
    wait_idle();
    ALUOp = 2'b10; funct = F_MULT; a = 32'd1234; b = 32'hFFFF_FF00; valid = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(mdu_model(F_MULT, 32'd1234, 32'hFFFF_FF00));
    funct = F_MFLO;
    scnt = 0; bad_rd = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (stall) begin
        scnt++;
        if (hilo_rd != 2'b00) bad_rd++;
      end else break;
    end
    check("stall cycles", 64'(scnt), 64'(W + 1));
    check("hilo_rd during stall", 64'(bad_rd), 64'd0);
    check("hilo_rd release", 64'(hilo_rd), 64'd2);
    check("busy at release", 64'(busy), 64'd0);
    e = exp_q.pop_front();
    check("stall mult lo", 64'(lo), 64'(e[31:0]));
    check("stall mult hi", 64'(hi), 64'(e[63:32]));
    $display("stall mflo: %0d stall cycles lo=%h", scnt, lo);
    @(posedge clk); #1;
    valid = 1'b0;

    // ALU op during busy never stalls; valid=0 never stalls
    ALUOp = 2'b10; funct = F_DIVU; a = 32'hDEAD_BEEF; b = 32'd1000; valid = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(mdu_model(F_DIVU, 32'hDEAD_BEEF, 32'd1000));
    funct = 6'b100000;
    @(negedge clk);
    check("add busy stall", 64'(stall), 64'd0);
    check("add busy sel", 64'(sel), 64'd2);
    check("add busy busy", 64'(busy), 64'd1);
    valid = 1'b0; funct = F_MFLO;
    @(negedge clk);
    check("invalid mflo stall", 64'(stall), 64'd0);
    wait_done("divu during add", 2);

    // Reset in the middle of an operation
    wait_idle();
    ALUOp = 2'b10; funct = F_MTHI; a = 32'h1234_5678; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    check("mthi hi", 64'(hi), 64'h1234_5678);
    funct = F_MULT; a = 32'd3; b = 32'd5; valid = 1'b1;
    @(posedge clk); #1;           // E0
    valid = 1'b0;
    repeat (9) @(posedge clk);    // E0+9
    #1 rst_n = 1'b0;
    @(posedge clk);               // E0+10
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset hi", 64'(hi), 64'd0);
    check("midreset lo", 64'(lo), 64'd0);
    $display("mid-op reset: busy=%b hi=%h lo=%h", busy, hi, lo);
    run_op("mult after reset", F_MULT, 32'hFFFF_FFF0, 32'h0001_0001);

    // A few random operations
    for (int n = 0; n < 6; n++) begin
      rf = optab[$urandom_range(0, 3)];
      rx = $urandom;
      ry = (n == 0) ? 32'd1 : $urandom;
      run_op($sformatf("random op %0d funct=%b", n, rf), rf, rx, ry);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
